// File: rtl/snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : snoop_responder
// Purpose  : Per-CPU coherence responder between a data-cache tag/state array
//            and a shared snooping bus. Answers bus snoop searches with hit,
//            block state and line data, then applies the downgrade or
//            invalidate. Also accepts local fill/write/evict updates from its
//            own CPU. Snoops win same-cycle conflicts with local requests.
// Revision : 1.0 - initial release
//
// Optional feature macro: MESI_EN
//   When defined, adds the Exclusive state (2'b11) and the loc_excl input.
//   When undefined, the block is pure MSI and 2'b11 is never produced.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_search, snoop_rd, BOCI bus snoop lookup request, read/write kind, addr
//   invalidate_from_other_cpu  bus invalidate-only request
//   snoop_busy                 responder is not idle
//   search_done                one-cycle pulse, snoop response valid
//   cpu_search_found           tag hit on a valid line (held until next resp)
//   block_state                state of the snooped line (held)
//   send_other_proc_data       snooped line data, 0 on miss (held)
//   inv_ack                    one-cycle pulse, invalidate applied
//   loc_req, loc_op, loc_addr, loc_wdata  local update request
//   loc_excl                   (MESI_EN only) fill in Exclusive state
//   loc_ready                  local request accepted this cycle
//   loc_state                  combinational state of the loc_addr line
// ============================================================================
module snoop_responder #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_search,
  input  logic              snoop_rd,
  input  logic [ADDR_W-1:0] BOCI,
  input  logic              invalidate_from_other_cpu,
  output logic              snoop_busy,
  output logic              search_done,
  output logic              cpu_search_found,
  output logic [1:0]        block_state,
  output logic [DATA_W-1:0] send_other_proc_data,
  output logic              inv_ack,
  input  logic              loc_req,
  input  logic [1:0]        loc_op,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
`ifdef MESI_EN
  input  logic              loc_excl,
`endif
  output logic              loc_ready,
  output logic [1:0]        loc_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;
`ifdef MESI_EN
  localparam logic [1:0] ST_E = 2'b11;
`endif

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_EVICT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    INV    = 2'd3
  } fsm_t;

  fsm_t state, state_nxt;

  // Line table
  logic [1:0]        line_st   [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];

  // Registered snoop request
  logic [ADDR_W-1:0] snp_addr;
  logic              snp_rd;

  logic [IDX_W-1:0]  snp_idx;
  logic [TAG_W-1:0]  snp_tag;
  logic              snp_hit;
  logic [IDX_W-1:0]  loc_idx;
  logic [TAG_W-1:0]  loc_tag;
  logic              loc_fire;

  assign snp_idx  = snp_addr[IDX_W-1:0];
  assign snp_tag  = snp_addr[ADDR_W-1:IDX_W];
  assign snp_hit  = (line_tag[snp_idx] == snp_tag) && (line_st[snp_idx] != ST_I);

  assign loc_idx  = loc_addr[IDX_W-1:0];
  assign loc_tag  = loc_addr[ADDR_W-1:IDX_W];
  assign loc_fire = loc_req & loc_ready;

  // An I line reads as 00 whether or not the tag matches.
  assign loc_state = (line_tag[loc_idx] == loc_tag) ? line_st[loc_idx] : ST_I;

  // --------------------------------------------------------------------------
  // Next-state and strobe outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    snoop_busy  = 1'b1;
    search_done = 1'b0;
    inv_ack     = 1'b0;
    loc_ready   = 1'b0;
    case (state)
      IDLE: begin
        snoop_busy = 1'b0;
        loc_ready  = ~cpu_search & ~invalidate_from_other_cpu;
        if (cpu_search)
          state_nxt = LOOKUP;
        else if (invalidate_from_other_cpu)
          state_nxt = INV;
      end
      LOOKUP: state_nxt = RESP;
      RESP: begin
        search_done = 1'b1;
        state_nxt   = IDLE;
      end
      INV: begin
        inv_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register, snoop capture, response registers and line table
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      snp_addr             <= '0;
      snp_rd               <= 1'b0;
      cpu_search_found     <= 1'b0;
      block_state          <= ST_I;
      send_other_proc_data <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_st[i]   <= ST_I;
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      case (state)
        IDLE: begin
          if (cpu_search) begin
            snp_addr <= BOCI;
            // A coincident invalidate turns the search into a write snoop.
            snp_rd   <= snoop_rd & ~invalidate_from_other_cpu;
          end else if (invalidate_from_other_cpu) begin
            snp_addr <= BOCI;
          end

          // Local updates only happen in IDLE, so they never race the
          // snoop-side writes below.
          if (loc_fire) begin
            case (loc_op)
              OP_FILL: begin
                line_tag[loc_idx]  <= loc_tag;
                line_data[loc_idx] <= loc_wdata;
`ifdef MESI_EN
                line_st[loc_idx]   <= loc_excl ? ST_E : ST_S;
`else
                line_st[loc_idx]   <= ST_S;
`endif
              end
              OP_WRITE: begin
                line_tag[loc_idx]  <= loc_tag;
                line_data[loc_idx] <= loc_wdata;
                line_st[loc_idx]   <= ST_M;
              end
              OP_EVICT: begin
                if (line_tag[loc_idx] == loc_tag)
                  line_st[loc_idx] <= ST_I;
              end
              default: ;
            endcase
          end
        end

        LOOKUP: begin
          cpu_search_found     <= snp_hit;
          block_state          <= snp_hit ? line_st[snp_idx] : ST_I;
          send_other_proc_data <= snp_hit ? line_data[snp_idx] : '0;
        end

        RESP: begin
          // Line cannot change between LOOKUP and here (no local updates
          // outside IDLE), so the registered hit is still valid.
          if (cpu_search_found)
            line_st[snp_idx] <= snp_rd ? ST_S : ST_I;
        end

        INV: begin
          if (snp_hit)
            line_st[snp_idx] <= ST_I;
        end

        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_responder
// Purpose  : Directed self-checking testbench for snoop_responder with
//            hand-computed expected values (LINES=8, ADDR_W=13, DATA_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_responder;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_search;
  logic              snoop_rd;
  logic [ADDR_W-1:0] BOCI;
  logic              invalidate_from_other_cpu;
  logic              snoop_busy;
  logic              search_done;
  logic              cpu_search_found;
  logic [1:0]        block_state;
  logic [DATA_W-1:0] send_other_proc_data;
  logic              inv_ack;
  logic              loc_req;
  logic [1:0]        loc_op;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
`ifdef MESI_EN
  logic              loc_excl;
`endif
  logic              loc_ready;
  logic [1:0]        loc_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snoop_responder #(.LINES(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .cpu_search                (cpu_search),
    .snoop_rd                  (snoop_rd),
    .BOCI                      (BOCI),
    .invalidate_from_other_cpu (invalidate_from_other_cpu),
    .snoop_busy                (snoop_busy),
    .search_done               (search_done),
    .cpu_search_found          (cpu_search_found),
    .block_state               (block_state),
    .send_other_proc_data      (send_other_proc_data),
    .inv_ack                   (inv_ack),
    .loc_req                   (loc_req),
    .loc_op                    (loc_op),
    .loc_addr                  (loc_addr),
    .loc_wdata                 (loc_wdata),
`ifdef MESI_EN
    .loc_excl                  (loc_excl),
`endif
    .loc_ready                 (loc_ready),
    .loc_state                 (loc_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek_state(input logic [ADDR_W-1:0] a, input logic [1:0] exp, input string tag);
    loc_addr = a;
    #1;
    check(tag, {30'd0, loc_state}, {30'd0, exp});
  endtask

  task automatic local_op(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    loc_req   = 1'b1;
    loc_op    = op;
    loc_addr  = a;
    loc_wdata = d;
    #1;
    check("loc_ready_idle", {31'd0, loc_ready}, 32'd1);
    tick();
    loc_req = 1'b0;
    loc_op  = 2'b11;
  endtask

  // Issue a snoop search and return positioned in the RESP cycle.
  task automatic snoop(input logic [ADDR_W-1:0] a, input logic rd);
    cpu_search = 1'b1;
    BOCI       = a;
    snoop_rd   = rd;
    tick();
    cpu_search = 1'b0;
    check("busy_lookup", {31'd0, snoop_busy}, 32'd1);
    check("done_early", {31'd0, search_done}, 32'd0);
    tick();
    check("search_done", {31'd0, search_done}, 32'd1);
  endtask

  task automatic resp(input logic f, input logic [1:0] bs, input logic [DATA_W-1:0] d,
                      input string tag);
    check({tag, "_found"}, {31'd0, cpu_search_found}, {31'd0, f});
    check({tag, "_bstate"}, {30'd0, block_state}, {30'd0, bs});
    check({tag, "_data"}, {16'd0, send_other_proc_data}, {16'd0, d});
  endtask

  task automatic invalidate(input logic [ADDR_W-1:0] a);
    invalidate_from_other_cpu = 1'b1;
    BOCI = a;
    tick();
    invalidate_from_other_cpu = 1'b0;
    check("inv_ack", {31'd0, inv_ack}, 32'd1);
    check("busy_inv", {31'd0, snoop_busy}, 32'd1);
    tick();
    check("inv_ack_drop", {31'd0, inv_ack}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_search = 1'b0;
    snoop_rd = 1'b0;
    BOCI = '0;
    invalidate_from_other_cpu = 1'b0;
    loc_req = 1'b0;
    loc_op = 2'b11;
    loc_addr = '0;
    loc_wdata = '0;
`ifdef MESI_EN
    loc_excl = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // 1. Reset state
    check("rst_busy", {31'd0, snoop_busy}, 32'd0);
    check("rst_done", {31'd0, search_done}, 32'd0);
    check("rst_inv_ack", {31'd0, inv_ack}, 32'd0);
    resp(1'b0, 2'b00, 16'h0000, "rst");
    for (int a = 0; a < 8; a++) peek_state(ADDR_W'(a), 2'b00, "rst_line");
    check("rst_loc_ready", {31'd0, loc_ready}, 32'd1);

    // 2. WRITE then snoop read: M -> S
    local_op(2'b01, 13'h0005, 16'hBEEF);
    peek_state(13'h0005, 2'b10, "write_m");
    snoop(13'h0005, 1'b1);
    resp(1'b1, 2'b10, 16'hBEEF, "rd_m");
    tick();
    check("done_pulse", {31'd0, search_done}, 32'd0);
    check("busy_idle", {31'd0, snoop_busy}, 32'd0);
    check("held_data", {16'd0, send_other_proc_data}, 32'h0000BEEF);
    peek_state(13'h0005, 2'b01, "m_to_s");

    // 3. Alias on same index rejected by tag compare
    local_op(2'b00, 13'h0013, 16'h1234);
    snoop(13'h0003, 1'b1);
    resp(1'b0, 2'b00, 16'h0000, "alias");
    tick();
    peek_state(13'h0013, 2'b01, "alias_keep");

    // 4. Invalidate hit and miss
    invalidate(13'h0013);
    peek_state(13'h0013, 2'b00, "inv_hit");
    invalidate(13'h0009);
    peek_state(13'h0005, 2'b01, "inv_miss_keep");

    // Snoop write on S line -> I
    snoop(13'h0005, 1'b0);
    resp(1'b1, 2'b01, 16'hBEEF, "wr_s");
    tick();
    peek_state(13'h0005, 2'b00, "s_to_i");

    // Simultaneous search + invalidate: write snoop, no inv_ack
    local_op(2'b00, 13'h0006, 16'h0A0A);
    cpu_search = 1'b1;
    invalidate_from_other_cpu = 1'b1;
    BOCI = 13'h0006;
    snoop_rd = 1'b1;
    #1;
    check("both_loc_ready", {31'd0, loc_ready}, 32'd0);
    tick();
    cpu_search = 1'b0;
    invalidate_from_other_cpu = 1'b0;
    check("both_no_ack", {31'd0, inv_ack}, 32'd0);
    tick();
    check("both_done", {31'd0, search_done}, 32'd1);
    resp(1'b1, 2'b01, 16'h0A0A, "both");
    tick();
    peek_state(13'h0006, 2'b00, "both_inv");

    // 5. Local write collides with search; snoop first
    loc_req = 1'b1;
    loc_op = 2'b01;
    loc_addr = 13'h0004;
    loc_wdata = 16'h5555;
    cpu_search = 1'b1;
    BOCI = 13'h0004;
    snoop_rd = 1'b1;
    #1;
    check("coll_rdy0", {31'd0, loc_ready}, 32'd0);
    tick();
    cpu_search = 1'b0;
    check("coll_rdy_lookup", {31'd0, loc_ready}, 32'd0);
    tick();
    check("coll_rdy_resp", {31'd0, loc_ready}, 32'd0);
    check("coll_done", {31'd0, search_done}, 32'd1);
    resp(1'b0, 2'b00, 16'h0000, "coll");
    tick();
    check("coll_rdy_idle", {31'd0, loc_ready}, 32'd1);
    tick();
    loc_req = 1'b0;
    loc_op = 2'b11;
    peek_state(13'h0004, 2'b10, "coll_write");

    // EVICT with mismatched tag leaves line, matching tag evicts
    local_op(2'b10, 13'h000C, 16'h0000);
    peek_state(13'h0004, 2'b10, "evict_miss");
    local_op(2'b10, 13'h0004, 16'h0000);
    peek_state(13'h0004, 2'b00, "evict_hit");

    // 6. Reset during LOOKUP
    local_op(2'b00, 13'h0001, 16'h7777);
    cpu_search = 1'b1;
    BOCI = 13'h0001;
    snoop_rd = 1'b1;
    tick();
    cpu_search = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_done", {31'd0, search_done}, 32'd0);
    check("mid_rst_busy", {31'd0, snoop_busy}, 32'd0);
    tick();
    check("mid_rst_done2", {31'd0, search_done}, 32'd0);
    resp(1'b0, 2'b00, 16'h0000, "mid_rst");
    peek_state(13'h0001, 2'b00, "mid_rst_line");

`ifdef MESI_EN
    loc_excl = 1'b1;
    local_op(2'b00, 13'h0002, 16'hCAFE);
    loc_excl = 1'b0;
    peek_state(13'h0002, 2'b11, "fill_e");
    snoop(13'h0002, 1'b1);
    resp(1'b1, 2'b11, 16'hCAFE, "rd_e");
    tick();
    peek_state(13'h0002, 2'b01, "e_to_s");
    loc_excl = 1'b1;
    local_op(2'b00, 13'h0003, 16'h1111);
    loc_excl = 1'b0;
    local_op(2'b01, 13'h0003, 16'h2222);
    peek_state(13'h0003, 2'b10, "e_to_m");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
